// File: rtl/hd_program_loader_pkg.sv
// Shared definitions for the program loader, instruction memory and control unit.
// Holds the block geometry, HD track size, lfhd opcode and the loader state encoding.
package hd_program_loader_pkg;

    localparam int unsigned TAM_BLOCO       = 200;   // words per process block
    localparam int unsigned NUM_SLOTS       = 8;     // process blocks in instruction memory
    localparam int unsigned HD_TRACK_WORDS  = 256;   // words reserved per program on the HD
    localparam int unsigned TIMEOUT_DEFAULT = 1023;  // cycles to wait for hd_valid

    localparam int unsigned OPC_W    = 6;
    localparam logic [OPC_W-1:0] OPC_LFHD = 6'h2B;   // load-from-HD instruction opcode

    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_CHECK = 3'd1;
    localparam logic [STATE_W-1:0] ST_REQ   = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd3;
    localparam logic [STATE_W-1:0] ST_WRITE = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;
    localparam logic [STATE_W-1:0] ST_ERR   = 3'd6;

endpackage

// File: rtl/hd_program_loader.sv
// Copies one program image from the HD into a process block of instruction memory.
// Ports: clock/reset (async, active-high); start/prog_id/slot/prog_len load command;
// hd_rd_en/hd_addr request and hd_data/hd_valid response from the HD;
// mem_we/mem_addr/mem_data instruction-memory write port;
// busy/done/error status and cursor (base of the last successfully loaded block).
module hd_program_loader
    import hd_program_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  prog_id,
    input  logic [2:0]  slot,
    input  logic [15:0] prog_len,
    output logic        hd_rd_en,
    output logic [31:0] hd_addr,
    input  logic [31:0] hd_data,
    input  logic        hd_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] cursor
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [7:0]         prog_id_q, prog_id_d;
    logic [7:0]         slot_q, slot_d;       // wider than the port so the range check stays a real compare
    logic [15:0]        prog_len_q, prog_len_d;
    logic [15:0]        n_q, n_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               hd_rd_en_q, hd_rd_en_d;
    logic [31:0]        hd_addr_q, hd_addr_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_data_q, mem_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [31:0]        cursor_q, cursor_d;
    logic [31:0]        base_c;

    // Destination block base: constant times a small slot index.
    assign base_c = 32'(slot_q) * TAM_BLOCO;

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            prog_id_q  <= '0;
            slot_q     <= '0;
            prog_len_q <= '0;
            n_q        <= '0;
            wait_q     <= '0;
            hd_rd_en_q <= 1'b0;
            hd_addr_q  <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cursor_q   <= '0;
        end else begin
            state_q    <= state_d;
            prog_id_q  <= prog_id_d;
            slot_q     <= slot_d;
            prog_len_q <= prog_len_d;
            n_q        <= n_d;
            wait_q     <= wait_d;
            hd_rd_en_q <= hd_rd_en_d;
            hd_addr_q  <= hd_addr_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cursor_q   <= cursor_d;
        end
    end

    // Next state; outputs are derived from the next state so each strobe
    // is registered and coincides exactly with its state.
    always_comb begin
        state_d    = state_q;
        prog_id_d  = prog_id_q;
        slot_d     = slot_q;
        prog_len_d = prog_len_q;
        n_d        = n_q;
        wait_d     = wait_q;
        hd_addr_d  = hd_addr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        cursor_d   = cursor_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    prog_id_d  = prog_id;
                    slot_d     = 8'(slot);
                    prog_len_d = prog_len;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (prog_len_q > 16'(TAM_BLOCO) || slot_q >= 8'(NUM_SLOTS)) begin
                    state_d = ST_ERR;
                end else if (prog_len_q == 16'd0) begin
                    state_d = ST_DONE;
                end else begin
                    n_d     = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (hd_valid) begin
                    mem_data_d = hd_data;
                    state_d    = ST_WRITE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_d == WAIT_W'(TIMEOUT)) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_WRITE: begin
                if (n_q == prog_len_q - 16'd1) begin
                    state_d = ST_DONE;
                end else begin
                    n_d     = n_q + 16'd1;
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                cursor_d = base_c;
                state_d  = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        hd_rd_en_d = (state_d == ST_REQ);
        mem_we_d   = (state_d == ST_WRITE);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERR);

        if (hd_rd_en_d) begin
            hd_addr_d = 32'(prog_id_q) * HD_TRACK_WORDS + 32'(n_d);
        end
        if (mem_we_d) begin
            mem_addr_d = base_c + 32'(n_d);
        end
    end

    assign hd_rd_en = hd_rd_en_q;
    assign hd_addr  = hd_addr_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign cursor   = cursor_q;

endmodule
